load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage consumer of the decoder's memory controls: takes MemWrite/MemRead, StoreSrc and LoadPart, and drives a request/grant/response data-memory bus.
- Generates byte enables and lane-replicated store data, and sign/zero-extends load data.
- Stalls the pipeline until the access completes.
- Sits between the EX/MEM pipeline register and data memory; its load result feeds the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for grant or response before bus error. Used only with LSU_TIMEOUT_EN.
- TO_W, 8: timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
MemWriteM  in  1  store in MEM stage
MemReadM  in  1  load in MEM stage
StoreSrcM  in  2  00 SW, 01 SH, 10 SB, 11 treated as SW
LoadPartM  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, other codes treated as LW
ALUResultM  in  32  byte address
WriteDataM  in  32  rs2 store data
StallM  out  1  hold IF..MEM stages
MisalignM  out  1  misaligned access flagged; no bus access made
BusErrM  out  1  one-cycle pulse on timeout (LSU_TIMEOUT_EN only, else tied 0)
LoadDataM  out  32  extended load result, valid in DONE
mem_req  out  1  bus request
mem_we  out  1  1 write, 0 read
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid; earliest the cycle after gnt
mem_rdata  in  32  read data word

Behaviour:
- Reset values: FSM IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, LoadDataM=0, BusErrM=0. StallM and MisalignM are combinational and 0 with no access.
- Access = MemWriteM|MemReadM. Both high: treat as store.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - MisalignM=1 combinationally in IDLE.
  - StallM=0, FSM stays IDLE, no request issued.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE, aligned access:
  - StallM=1.
  - Register addr, we, be, wdata, LoadPart, addr[1:0].
  - Go to REQ.
- REQ:
  - mem_req=1, StallM=1.
  - On mem_gnt: store goes to DONE, load goes to WAIT_R.
  - mem_req drops the cycle after gnt.
- WAIT_R:
  - StallM=1.
  - On mem_rvalid: register the extended data into LoadDataM, go to DONE.
  - rvalid in any other state is ignored.
- DONE:
  - StallM=0 for exactly one cycle; the pipeline advances.
  - LoadDataM holds its value until the next load completes.
  - Go to IDLE; the new MEM instruction is evaluated there, so there is no re-trigger.
- Latency (StallM high cycles): store with immediate gnt = 2; load with gnt then rvalid next cycle = 3.
- Byte enables: SB gives 0001<<a; SH gives 0011<<a; SW gives 1111 (a = addr[1:0]).
- Store data lanes: SB {4{b}}, SH {2{h}}, SW unchanged.
- Load lane select:
  - Byte = rdata[8a+7:8a].
  - Half = rdata[16a[1]+15:16a[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Reset asserted mid-access: immediate return to IDLE, mem_req=0. A late rvalid/gnt after reset is ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - TO_W-bit counter, cleared on entering REQ or WAIT_R, incrementing each cycle in those states.
  - When the counter reaches TIMEOUT_CYCLES without gnt or rvalid: BusErrM pulses for 1 cycle, mem_req=0, LoadDataM unchanged, FSM goes to DONE.
- Undefined: no counter; the FSM waits indefinitely; BusErrM is constant 0.

Decomposition:
- Shared package riscv_pkg:
  - lsu_state_t enum {IDLE, REQ, WAIT_R, DONE}.
  - StoreSrc constants ST_W=2'b00, ST_H=2'b01, ST_B=2'b10.
  - LoadPart constants LD_B=3'b000, LD_H=3'b001, LD_W=3'b010, LD_BU=3'b100, LD_HU=3'b101.
- One sub-module, load_extend: purely combinational lane select plus sign/zero extension, instantiated on the mem_rdata path.

Test Plan:
- SB addr 0x1003, data 0x000000AB, gnt immediate:
  - mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000, mem_we=1.
  - StallM high for 2 cycles.
- LB addr 0x2001, rdata 0x0000_80FF, rvalid the cycle after gnt: LoadDataM=0xFFFFFF80, StallM high for 3 cycles.
- LHU addr 0x2002, rdata 0x8001_1234: LoadDataM=0x00008001. Repeat with LH: LoadDataM=0xFFFF8001.
- LW addr 0x3002: MisalignM=1, StallM=0, mem_req stays 0. Same for SH addr 0x3001.
- gnt delayed 5 cycles on SW: mem_req held 5 cycles with stable addr/be/wdata; StallM high for 6 cycles; rst_n pulsed in WAIT_R of a later load: mem_req=0 and FSM IDLE immediately, next-cycle rvalid ignored.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, gnt never asserted: BusErrM pulses once after 4 REQ cycles, then DONE, then IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and encodings for the memory stage: LSU state, StoreSrc/LoadPart codes
// and the access-size helpers used for byte enables and alignment checks.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        WAIT_R = 2'b10,
        DONE   = 2'b11
    } lsu_state_t;

    localparam logic [1:0] ST_W = 2'b00;
    localparam logic [1:0] ST_H = 2'b01;
    localparam logic [1:0] ST_B = 2'b10;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // StoreSrc 11 falls through to a word store
    function automatic logic [1:0] store_size(input logic [1:0] src);
        case (src)
            ST_B:    return SZ_B;
            ST_H:    return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic [1:0] load_size(input logic [2:0] part);
        case (part)
            LD_B, LD_BU: return SZ_B;
            LD_H, LD_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            SZ_B:    return 4'b0001 << ofs;
            SZ_H:    return 4'b0011 << ofs;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load lane select with sign/zero extension on the read-data path.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_part,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (offset)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

        case (load_part)
            LD_B:    data = {{24{lane_b[7]}}, lane_b};
            LD_H:    data = {{16{lane_h[15]}}, lane_h};
            LD_BU:   data = {24'd0, lane_b};
            LD_HU:   data = {16'd0, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit driving a req/gnt/rvalid data bus and stalling until done.
// Optional bus timeout with BusErrM pulse: define LSU_TIMEOUT_EN.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [1:0]  StoreSrcM,
    input  logic [2:0]  LoadPartM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic [31:0] LoadDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state, next_state;
    logic        access, misalign, start, timeout;
    logic [1:0]  size;
    logic [1:0]  offset;
    logic [2:0]  load_part;
    logic [31:0] ext_data;
    logic [31:0] store_data;

    // A write wins when both controls are raised
    assign access    = MemWriteM | MemReadM;
    assign size      = MemWriteM ? store_size(StoreSrcM) : load_size(LoadPartM);
    assign misalign  = ((size == SZ_H) && ALUResultM[0]) ||
                       ((size == SZ_W) && (ALUResultM[1:0] != 2'b00));
    assign MisalignM = (state == IDLE) && access && misalign;
    assign start     = (state == IDLE) && access && !misalign;
    assign mem_req   = (state == REQ);

    always_comb begin
        case (size)
            SZ_B:    store_data = {4{WriteDataM[7:0]}};
            SZ_H:    store_data = {2{WriteDataM[15:0]}};
            default: store_data = WriteDataM;
        endcase
    end

    always_comb begin
        next_state = state;
        StallM     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    StallM     = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                StallM = 1'b1;
                if (mem_gnt)
                    next_state = mem_we ? DONE : WAIT_R;
                else if (timeout)
                    next_state = DONE;
            end
            WAIT_R: begin
                StallM = 1'b1;
                if (mem_rvalid || timeout)
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            load_part <= LD_W;
            offset    <= 2'd0;
            LoadDataM <= 32'd0;
        end else begin
            state <= next_state;
            if (start) begin
                mem_we    <= MemWriteM;
                mem_addr  <= {ALUResultM[31:2], 2'b00};
                mem_be    <= byte_enables(size, ALUResultM[1:0]);
                mem_wdata <= store_data;
                load_part <= LoadPartM;
                offset    <= ALUResultM[1:0];
            end
            if ((state == WAIT_R) && mem_rvalid)
                LoadDataM <= ext_data;
        end
    end

    load_extend u_load_extend (
        .rdata     (mem_rdata),
        .offset    (offset),
        .load_part (load_part),
        .data      (ext_data)
    );

`ifdef LSU_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every state change, so it is zero on entry to REQ/WAIT_R
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            BusErrM <= 1'b0;
        end else begin
            BusErrM <= timeout && (((state == REQ) && !mem_gnt) ||
                                   ((state == WAIT_R) && !mem_rvalid));
            if (next_state != state)
                to_cnt <= '0;
            else if ((state == REQ) || (state == WAIT_R))
                to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign BusErrM    = 1'b0;
    assign unused_cfg = (TIMEOUT_CYCLES > 0) && (TO_W > 0);
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, misalignment, delayed grant, reset mid-access.
module tb_load_store_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWriteM, MemReadM;
    logic [1:0]  StoreSrcM;
    logic [2:0]  LoadPartM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallM, MisalignM, BusErrM;
    logic [31:0] LoadDataM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    int          n_stall, n_req, n_err;
    logic [31:0] o_addr, o_wdata, o_ld;
    logic [3:0]  o_be;
    logic        o_we, o_stable;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .StoreSrcM  (StoreSrcM),
        .LoadPartM  (LoadPartM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .LoadDataM  (LoadDataM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the edge that leaves DONE.
    // gnt_delay = n grants on the n-th REQ cycle (0 = never grant).
    task automatic run_access(input logic we, input logic re, input logic [1:0] st,
                              input logic [2:0] ld, input logic [31:0] addr,
                              input logic [31:0] wd, input int gnt_delay,
                              input logic [31:0] rdata);
        logic done    = 1'b0;
        logic rv_pend = 1'b0;
        MemWriteM  = we;
        MemReadM   = re;
        StoreSrcM  = st;
        LoadPartM  = ld;
        ALUResultM = addr;
        WriteDataM = wd;
        n_stall = 0; n_req = 0; n_err = 0; o_stable = 1'b1;
        o_addr = 32'd0; o_be = 4'd0; o_wdata = 32'd0; o_we = 1'b0; o_ld = 32'd0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (BusErrM) n_err++;
            if (rv_pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                rv_pend    = 1'b0;
            end
            if (mem_req) begin
                n_req++;
                if (n_req == 1) begin
                    o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
                end else if (mem_addr !== o_addr || mem_be !== o_be || mem_wdata !== o_wdata)
                    o_stable = 1'b0;
                if (n_req == gnt_delay) begin
                    mem_gnt = 1'b1;
                    rv_pend = !mem_we;
                end
            end
            if (StallM) n_stall++;
            else begin
                done = 1'b1;
                o_ld = LoadDataM;
            end
            @(posedge clk); #1;
        end
        MemWriteM  = 1'b0;
        MemReadM   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (!done) check("access_bound", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        MemWriteM = 1'b0; MemReadM = 1'b0; StoreSrcM = ST_W; LoadPartM = LD_W;
        ALUResultM = 32'd0; WriteDataM = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   32'(mem_req),   32'd0);
        check("rst_we",    32'(mem_we),    32'd0);
        check("rst_addr",  mem_addr,       32'd0);
        check("rst_be",    32'(mem_be),    32'd0);
        check("rst_wdata", mem_wdata,      32'd0);
        check("rst_ld",    LoadDataM,      32'd0);
        check("rst_berr",  32'(BusErrM),   32'd0);
        check("rst_stall", 32'(StallM),    32'd0);
        check("rst_mis",   32'(MisalignM), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // SB at byte 3, immediate grant
        run_access(1'b1, 1'b0, ST_B, LD_W, 32'h0000_1003, 32'h0000_00AB, 1, 32'd0);
        check("sb_be",    32'(o_be),    32'h8);
        check("sb_wdata", o_wdata,      32'hABAB_ABAB);
        check("sb_addr",  o_addr,       32'h0000_1000);
        check("sb_we",    32'(o_we),    32'd1);
        check("sb_stall", n_stall,      32'd2);

        // SH on the low half
        run_access(1'b1, 1'b0, ST_H, LD_W, 32'h0000_0010, 32'h1234_5678, 1, 32'd0);
        check("sh_be",    32'(o_be), 32'h3);
        check("sh_wdata", o_wdata,   32'h5678_5678);

        // LB at byte 1, rvalid the cycle after grant
        run_access(1'b0, 1'b1, ST_W, LD_B, 32'h0000_2001, 32'd0, 1, 32'h0000_80FF);
        check("lb_data",  o_ld,      32'hFFFF_FF80);
        check("lb_stall", n_stall,   32'd3);
        check("lb_we",    32'(o_we), 32'd0);
        check("lb_addr",  o_addr,    32'h0000_2000);

        run_access(1'b0, 1'b1, ST_W, LD_HU, 32'h0000_2002, 32'd0, 1, 32'h8001_1234);
        check("lhu_data", o_ld, 32'h0000_8001);
        run_access(1'b0, 1'b1, ST_W, LD_BU, 32'h0000_0003, 32'd0, 1, 32'h9A00_0000);
        check("lbu_data", o_ld, 32'h0000_009A);
        run_access(1'b0, 1'b1, ST_W, LD_W, 32'h0000_0040, 32'd0, 1, 32'hDEAD_BEEF);
        check("lw_data", o_ld, 32'hDEAD_BEEF);
        run_access(1'b0, 1'b1, ST_W, LD_H, 32'h0000_2002, 32'd0, 1, 32'h8001_1234);
        check("lh_data", o_ld, 32'hFFFF_8001);

        // SW with grant on the 5th request cycle; load result must be untouched
        run_access(1'b1, 1'b0, ST_W, LD_W, 32'h0000_0080, 32'hCAFE_F00D, 5, 32'd0);
        check("sw_reqcyc", n_req,        32'd5);
        check("sw_stable", 32'(o_stable), 32'd1);
        check("sw_stall",  n_stall,      32'd6);
        check("sw_wdata",  o_wdata,      32'hCAFE_F00D);
        check("ld_hold",   LoadDataM,    32'hFFFF_8001);

        // Misaligned LW and SH: flagged, no stall, no request
        MemReadM = 1'b1; LoadPartM = LD_W; ALUResultM = 32'h0000_3002;
        #1;
        check("mis_lw_flag",  32'(MisalignM), 32'd1);
        check("mis_lw_stall", 32'(StallM),    32'd0);
        @(posedge clk); #2;
        check("mis_lw_req",   32'(mem_req),   32'd0);
        check("mis_lw_flag2", 32'(MisalignM), 32'd1);
        MemReadM = 1'b0;
        MemWriteM = 1'b1; StoreSrcM = ST_H; ALUResultM = 32'h0000_3001;
        #1;
        check("mis_sh_flag",  32'(MisalignM), 32'd1);
        check("mis_sh_stall", 32'(StallM),    32'd0);
        @(posedge clk); #2;
        check("mis_sh_req",   32'(mem_req),   32'd0);
        MemWriteM = 1'b0;
        @(posedge clk); #1;

        // Reset while waiting for read data; the late rvalid must be ignored
        MemReadM = 1'b1; LoadPartM = LD_W; ALUResultM = 32'h0000_0044;
        @(posedge clk); #2;
        check("rst_mid_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        #1;
        check("rst_mid_wait", 32'(StallM), 32'd1);
        rst_n = 1'b0;
        MemReadM = 1'b0;
        #1;
        check("rst_mid_req0",  32'(mem_req), 32'd0);
        check("rst_mid_stall", 32'(StallM),  32'd0);
        check("rst_mid_ld",    LoadDataM,    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        #1;
        check("late_rv_ld",    LoadDataM,    32'd0);
        check("late_rv_stall", 32'(StallM),  32'd0);
        check("late_rv_req",   32'(mem_req), 32'd0);
        @(posedge clk); #1;

`ifdef LSU_TIMEOUT_EN
        // Grant never arrives: 4 REQ cycles, one BusErrM pulse, then DONE and IDLE
        run_access(1'b1, 1'b0, ST_W, LD_W, 32'h0000_0100, 32'h1111_2222, 0, 32'd0);
        check("to_reqcyc", n_req,   32'd4);
        check("to_pulses", n_err,   32'd1);
        check("to_stall",  n_stall, 32'd5);
        #1;
        check("to_berr_off", 32'(BusErrM), 32'd0);
        check("to_idle",     32'(StallM),  32'd0);
`else
        check("berr_tied", 32'(BusErrM), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
